// File: rtl/snn_pkg.sv
// Shared SNN definitions: spike-rate decoder state encoding, LIF constants and a saturating-increment helper.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } dec_state_t;

    localparam int LIF_THRESHOLD  = 16;
    localparam int LIF_LEAK_SHIFT = 3;

    // Increment by one when enabled, holding at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] count,
                                            input logic        en,
                                            input logic [31:0] max_val);
        sat_inc = (en && (count < max_val)) ? count + 32'd1 : count;
    endfunction

endpackage

// File: rtl/spike_counter_sat.sv
// One saturating spike counter; clr has priority over counting.
// Single-cycle update, no backpressure.
module spike_counter_sat
    import snn_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             spike,
    output logic [CNT_W-1:0] count
);

    localparam logic [31:0] MAX_VAL = 32'((64'd1 << CNT_W) - 64'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= CNT_W'(sat_inc(32'(count), en & spike, MAX_VAL));
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per output line over WINDOW cycles, then serially scans for the most active line.
// Result valid WINDOW+NUM_OUTPUTS-1 edges after start; held in DONE until result_ready.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter  int NUM_OUTPUTS = 2,
    parameter  int WINDOW      = 64,
    parameter  int CNT_W       = 8,
    localparam int IDX_W       = $clog2(NUM_OUTPUTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_OUTPUTS-1:0]       spikes_in,
    output logic                         busy,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [IDX_W-1:0]             winner,
    output logic [CNT_W-1:0]             winner_count,
    output logic                         tie,
    output logic [NUM_OUTPUTS*CNT_W-1:0] counts_flat
);

    localparam int WC_W = $clog2(WINDOW + 1);

    dec_state_t       state, next_state;
    logic [WC_W-1:0]  win_ctr;
    logic [IDX_W-1:0] scan_idx;
    logic             clr;
    logic             count_en;
    logic [CNT_W-1:0] cnt [NUM_OUTPUTS];

    logic             first_scan;
    logic [CNT_W-1:0] base_best;
    logic [IDX_W-1:0] base_winner;
    logic             base_tie;
    logic [CNT_W-1:0] cand;

    assign count_en     = (state == ST_COUNT);
    assign busy         = (state == ST_COUNT) || (state == ST_SCAN);
    assign result_valid = (state == ST_DONE);

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_ch
        spike_counter_sat #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .en    (count_en),
            .spike (spikes_in[i]),
            .count (cnt[i])
        );
        assign counts_flat[i*CNT_W +: CNT_W] = cnt[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        clr        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_COUNT;
                    clr        = 1'b1;
                end
            end
            ST_COUNT: begin
                if (win_ctr == WC_W'(WINDOW - 1)) begin
                    next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_idx == IDX_W'(NUM_OUTPUTS - 1)) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    if (start) begin
                        next_state = ST_COUNT;
                        clr        = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_ctr  <= '0;
            scan_idx <= '0;
        end else begin
            if (clr) begin
                win_ctr <= '0;
            end else if (state == ST_COUNT) begin
                win_ctr <= win_ctr + WC_W'(1);
            end
            if (state == ST_COUNT) begin
                scan_idx <= IDX_W'(1);
            end else if (state == ST_SCAN) begin
                scan_idx <= scan_idx + IDX_W'(1);
            end
        end
    end

    // The first scan step compares against channel 0 directly, since the last
    // count sample lands on the same edge that enters SCAN.
    always_comb begin
        first_scan  = (scan_idx == IDX_W'(1));
        base_best   = first_scan ? cnt[0] : winner_count;
        base_winner = first_scan ? '0     : winner;
        base_tie    = first_scan ? 1'b0   : tie;
        cand        = cnt[scan_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner       <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
        end else if (state == ST_SCAN) begin
            if (cand > base_best) begin
                winner       <= scan_idx;
                winner_count <= cand;
                tie          <= 1'b0;
            end else begin
                winner       <= base_winner;
                winner_count <= base_best;
                tie          <= base_tie | (cand == base_best);
            end
        end
    end

endmodule
